// File: rtl/wave_generator.sv
// Phase-accumulator waveform generator: a restoring divider turns a frequency in Hz
// into a per-clock phase increment that drives triangle/saw/square/inverted-saw output.
module wave_generator #(
    parameter int BASE_SPEED = 50000000,
    parameter int OUT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int FREQ_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq,
    input  logic [1:0]        mode,
    input  logic [OUT_W-1:0]  duty,
    input  logic              sync,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              wrap
);

    localparam int REM_W = $clog2(BASE_SPEED) + 1;
    localparam int CNT_W = $clog2(ACC_W) + 1;
    localparam logic [REM_W-1:0]  BASE_R    = REM_W'(BASE_SPEED);
    localparam logic [63:0]       HALF_64   = 64'(BASE_SPEED / 2);
    localparam logic [FREQ_W-1:0] HALF_F    = FREQ_W'(BASE_SPEED / 2);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(ACC_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   phase_q, phase_d;
    logic [ACC_W-1:0]   inc_q, inc_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [FREQ_W-1:0]  freq_raw_q, freq_raw_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_q, wrap_d;

    logic [FREQ_W-1:0]  freq_clamped;
    logic [REM_W-1:0]   rem_src;
    logic [REM_W-1:0]   rem_sh;
    logic [ACC_W:0]     phase_sum;
    logic [OUT_W:0]     tri_p;
    logic [OUT_W-1:0]   saw_s;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (freq != freq_raw_q) state_d = DIV;
            DIV:     if (cnt_q == LAST_ITER) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // The first iteration takes its dividend straight from the freshly captured clamped frequency.
    always_comb begin
        freq_clamped = (64'(freq) > HALF_64) ? HALF_F : freq;
        rem_src      = (cnt_q == '0) ? REM_W'(freq_q) : rem_q;
        rem_sh       = rem_src << 1;
    end

    always_comb begin
        freq_d     = freq_q;
        freq_raw_d = freq_raw_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        inc_d      = inc_q;
        case (state_q)
            IDLE: begin
                if (freq != freq_raw_q) begin
                    freq_raw_d = freq;
                    freq_d     = freq_clamped;
                    quot_d     = '0;
                    cnt_d      = '0;
                end
            end
            DIV: begin
                if (rem_sh >= BASE_R) begin
                    rem_d  = rem_sh - BASE_R;
                    quot_d = {quot_q[ACC_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    quot_d = {quot_q[ACC_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            LOAD:    inc_d = quot_q;
            default: ;
        endcase
    end

    // Accumulator and wrap; a zero increment parks the phase at 0.
    always_comb begin
        phase_sum = {1'b0, phase_q} + {1'b0, inc_q};
        phase_d   = phase_sum[ACC_W-1:0];
        wrap_d    = phase_sum[ACC_W];
        if (sync || (inc_q == '0)) begin
            phase_d = '0;
            wrap_d  = 1'b0;
        end
    end

    always_comb begin
        tri_p = phase_q[ACC_W-1 -: OUT_W+1];
        saw_s = phase_q[ACC_W-1 -: OUT_W];
        out_d = '0;
        case (mode)
            2'd0:    out_d = tri_p[OUT_W] ? ~tri_p[OUT_W-1:0] : tri_p[OUT_W-1:0];
            2'd1:    out_d = saw_s;
            2'd2:    out_d = (saw_s < duty) ? '1 : '0;
            2'd3:    out_d = ~saw_s;
            default: out_d = '0;
        endcase
        if (inc_q == '0) out_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            inc_q      <= '0;
            freq_q     <= '0;
            freq_raw_q <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            inc_q      <= inc_d;
            freq_q     <= freq_d;
            freq_raw_q <= freq_raw_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            wrap_q     <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule
